dual_issue_sched: RTL and testbench
===================================

Name: dual_issue_sched

Overview:
- Front-end issue scheduler for the superscalar MIPS pipeline.
- Sits between fetch and the two decode/control lanes, each lane having its own control decoder.
- Buffers fetched instructions in a circular queue and issues up to two per cycle in program order.
- Enforces pairing rules (RAW/WAW, single memory port, branches alone) and a one-cycle load-use stall.

Parameters:
- DEPTH, 8, queue entries; power of two, at least 4.
- AW, 3, log2(DEPTH); pointer width. Count width is AW+1.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  branch mispredict or redirect; empties the queue.
- fetch_valid  in  2  bit0 = instr0 valid, bit1 = instr1 valid. 2'b10 is treated as 2'b00.
- fetch_instr0, fetch_instr1  in  32 each  fetched words, in program order.
- fetch_pc0, fetch_pc1  in  32 each  PCs of those words.
- fetch_ready  out  1  free entries >= 2.
- issue_stall  in  1  downstream back-pressure; no pop this cycle.
- issue0_valid, issue1_valid  out  1 each  slot issue indications.
- issue0_instr, issue1_instr  out  32 each.
- issue0_pc, issue1_pc  out  32 each.
- count  out  AW+1  occupancy.

Behaviour:
- Reset (reset=0, async):
  - head, tail and count are 0; load scoreboard is invalid.
  - All issue*_valid are 0; fetch_ready is 1.
- Push:
  - Accepted when fetch_ready && fetch_valid[0].
  - Writes instr0, then instr1 if fetch_valid[1]; tail advances by 1 or 2, modulo DEPTH.
  - fetch_ready is computed from the count at the start of the cycle; same-cycle pops are not credited.
  - A pushed entry is visible at head no earlier than the next cycle.
- Decode classes, taken from opcode [31:26]:
  - R-type 000000: srcs rs, rt; dest rd.
  - LW 100011: src rs; dest rt; load.
  - SW 101011: srcs rs, rt; no dest; mem.
  - BEQ 000100 / BNE 000101: srcs rs, rt; no dest; branch.
  - ADDI/ADDIU/ANDI/ORI/XORI/SLTI/SLTIU (0010xx, 0011xx except LUI): src rs; dest rt.
  - LUI 001111: no src; dest rt.
  - LW counts as mem.
  - Any other opcode is illegal: no src, no dest, never pairs.
  - A dest of $0 counts as no dest.
- Load scoreboard:
  - When a LW issues in either slot, ld_dest and ld_valid are registered for exactly one cycle.
  - If both slots would load, only slot0 can issue a load (see mem rule), so a single scoreboard entry suffices.
- Slot0 (I0 = head) issues when all hold:
  - count >= 1;
  - !flush;
  - no load-use hazard: ld_valid and ld_dest equals any src of I0.
- Slot1 (I1 = head+1) issues when issue0 issues, count >= 2, and none of these apply:
  - I1 src equals I0 dest (RAW);
  - I1 dest equals I0 dest, both nonzero (WAW);
  - both are mem;
  - either is a branch;
  - either is illegal;
  - load-use hazard on I1.
- Issue outputs are combinational from queue state and the scoreboard. issue1_valid=1 implies issue0_valid=1.
- Pop:
  - When !issue_stall, head advances by issue0_valid + issue1_valid.
  - When issue_stall=1, nothing pops and the scoreboard clears; the stalled load is not treated as issued.
- Occupancy: count_next = count + pushes - pops. Simultaneous push and pop on a full queue is legal.
- Flush:
  - Overrides push, pop and issue: issue*_valid=0 that cycle.
  - Next state: head = tail = count = 0, scoreboard cleared.
- Wrap-around: head+1 and tail+1 use AW-bit modulo arithmetic.
- Reset asserted mid-operation discards all entries immediately.

Test Plan:
- Independent pair: push ADD $3,$1,$2 and ORI $4,$5,1, then idle one cycle -> both issue valid the same cycle; count goes 2 -> 0.
- RAW split: ADD $3,$1,$2 then SUB $6,$3,$4 -> cycle n issues only slot0; cycle n+1 issues SUB in slot0.
- Load-use stall: LW $8,0($9) then ADD $10,$8,$1 -> LW issues alone; next cycle issue0_valid=0; the cycle after, ADD issues.
- Memory/branch rules:
  - LW then SW -> issued in separate cycles.
  - BEQ then ADDI -> BEQ issues alone.
  - ADD then BNE -> ADD issues alone.
- Full/wrap: with DEPTH=8, push 4 pairs under issue_stall=1 -> count=8, fetch_ready=0. Release the stall -> entries pop in PC order across wrap; fetch_ready returns at count<=6.
- Flush and reset: flush with count=5 -> issue*_valid=0 that cycle, count=0 next. Assert reset mid-push -> count=0 asynchronously, fetch_ready=1.

Source files
------------

// File: rtl/dual_issue_sched.sv
// Two-wide in-order issue scheduler: a circular fetch queue feeding two decode lanes,
// with RAW/WAW, memory-port, branch and one-cycle load-use pairing checks.
module dual_issue_sched #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic [1:0]    fetch_valid,
  input  logic [31:0]   fetch_instr0,
  input  logic [31:0]   fetch_instr1,
  input  logic [31:0]   fetch_pc0,
  input  logic [31:0]   fetch_pc1,
  output logic          fetch_ready,
  input  logic          issue_stall,
  output logic          issue0_valid,
  output logic          issue1_valid,
  output logic [31:0]   issue0_instr,
  output logic [31:0]   issue1_instr,
  output logic [31:0]   issue0_pc,
  output logic [31:0]   issue1_pc,
  output logic [AW:0]   count
);

  localparam int CW = AW + 1;

  typedef struct packed {
    logic [4:0] s0;
    logic       s0v;
    logic [4:0] s1;
    logic       s1v;
    logic [4:0] dst;   // 0 means no destination
    logic       mem;
    logic       load;
    logic       br;
    logic       ill;
  } dec_t;

  function automatic dec_t decode(input logic [31:0] ins);
    dec_t d;
    d = '0;
    case (ins[31:26])
      6'b000000: begin
        d.s0 = ins[25:21]; d.s0v = 1'b1;
        d.s1 = ins[20:16]; d.s1v = 1'b1;
        d.dst = ins[15:11];
      end
      6'b100011: begin
        d.s0 = ins[25:21]; d.s0v = 1'b1;
        d.dst = ins[20:16];
        d.mem = 1'b1; d.load = 1'b1;
      end
      6'b101011: begin
        d.s0 = ins[25:21]; d.s0v = 1'b1;
        d.s1 = ins[20:16]; d.s1v = 1'b1;
        d.mem = 1'b1;
      end
      6'b000100, 6'b000101: begin
        d.s0 = ins[25:21]; d.s0v = 1'b1;
        d.s1 = ins[20:16]; d.s1v = 1'b1;
        d.br = 1'b1;
      end
      6'b001111: d.dst = ins[20:16];
      6'b001000, 6'b001001, 6'b001010, 6'b001011,
      6'b001100, 6'b001101, 6'b001110: begin
        d.s0 = ins[25:21]; d.s0v = 1'b1;
        d.dst = ins[20:16];
      end
      default: d.ill = 1'b1;
    endcase
    return d;
  endfunction

  function automatic logic reads(input dec_t d, input logic [4:0] r);
    return (d.s0v && d.s0 == r) || (d.s1v && d.s1 == r);
  endfunction

  logic [31:0]   instr_q [DEPTH];
  logic [31:0]   pc_q    [DEPTH];
  logic [AW-1:0] head, tail, head1, tail1;
  logic          ld_valid;
  logic [4:0]    ld_dest;

  dec_t          d0, d1;
  logic          push_ok, push_two;
  logic [1:0]    npush, npop;
  logic          lu0, lu1, pair_ok;
  logic          ld_valid_nxt;
  logic [4:0]    ld_dest_nxt;

  assign head1 = head + 1'b1;
  assign tail1 = tail + 1'b1;

  assign fetch_ready = (count <= CW'(DEPTH - 2));
  assign push_ok     = fetch_ready && fetch_valid[0] && !flush;
  assign push_two    = push_ok && fetch_valid[1];
  assign npush       = {push_two, push_ok && !push_two};

  assign issue0_instr = instr_q[head];
  assign issue0_pc    = pc_q[head];
  assign issue1_instr = instr_q[head1];
  assign issue1_pc    = pc_q[head1];

  assign d0 = decode(issue0_instr);
  assign d1 = decode(issue1_instr);

  // The scoreboard only ever holds a nonzero register, so $0 sources never match.
  assign lu0 = ld_valid && reads(d0, ld_dest);
  assign lu1 = ld_valid && reads(d1, ld_dest);

  assign pair_ok = !(d0.dst != 5'd0 && reads(d1, d0.dst))
                && !(d0.dst != 5'd0 && d1.dst == d0.dst)
                && !(d0.mem && d1.mem)
                && !(d0.br || d1.br)
                && !(d0.ill || d1.ill)
                && !lu1;

  assign issue0_valid = (count != '0) && !flush && !lu0;
  assign issue1_valid = issue0_valid && (count >= CW'(2)) && pair_ok;

  assign npop = issue_stall ? 2'd0 : {1'b0, issue0_valid} + {1'b0, issue1_valid};

  always_comb begin
    ld_valid_nxt = 1'b0;
    ld_dest_nxt  = 5'd0;
    if (!issue_stall) begin
      if (issue0_valid && d0.load && d0.dst != 5'd0) begin
        ld_valid_nxt = 1'b1;
        ld_dest_nxt  = d0.dst;
      end else if (issue1_valid && d1.load && d1.dst != 5'd0) begin
        ld_valid_nxt = 1'b1;
        ld_dest_nxt  = d1.dst;
      end
    end
  end

  // Queue storage carries no reset; occupancy is tracked by head/tail/count.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      instr_q[tail] <= fetch_instr0;
      pc_q[tail]    <= fetch_pc0;
    end
    if (push_two) begin
      instr_q[tail1] <= fetch_instr1;
      pc_q[tail1]    <= fetch_pc1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      ld_valid <= 1'b0;
      ld_dest  <= 5'd0;
    end else if (flush) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      ld_valid <= 1'b0;
      ld_dest  <= 5'd0;
    end else begin
      head     <= head + AW'(npop);
      tail     <= tail + AW'(npush);
      count    <= count + CW'(npush) - CW'(npop);
      ld_valid <= ld_valid_nxt;
      ld_dest  <= ld_dest_nxt;
    end
  end

endmodule

// File: tb/tb_dual_issue_sched.sv
// Bench for dual_issue_sched: directed pairing/stall/wrap/flush scenarios plus
// randomized traffic compared against a queue-based reference model.
module tb_dual_issue_sched;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          flush = 1'b0;
  logic [1:0]    fetch_valid = 2'b00;
  logic [31:0]   fetch_instr0 = '0, fetch_instr1 = '0, fetch_pc0 = '0, fetch_pc1 = '0;
  logic          fetch_ready;
  logic          issue_stall = 1'b0;
  logic          issue0_valid, issue1_valid;
  logic [31:0]   issue0_instr, issue1_instr, issue0_pc, issue1_pc;
  logic [AW:0]   count;

  int checks = 0;
  int errors = 0;

  dual_issue_sched #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .fetch_valid(fetch_valid), .fetch_instr0(fetch_instr0), .fetch_instr1(fetch_instr1),
    .fetch_pc0(fetch_pc0), .fetch_pc1(fetch_pc1), .fetch_ready(fetch_ready),
    .issue_stall(issue_stall), .issue0_valid(issue0_valid), .issue1_valid(issue1_valid),
    .issue0_instr(issue0_instr), .issue1_instr(issue1_instr),
    .issue0_pc(issue0_pc), .issue1_pc(issue1_pc), .count(count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rtype(int rs, int rt, int rd, int funct);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(funct)};
  endfunction
  function automatic logic [31:0] itype(int op, int rs, int rt, int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  // Inputs change on the falling edge; outputs are sampled 2 units later, before the next rise.
  task automatic step(input logic [1:0] fv, input logic [31:0] i0, input logic [31:0] i1,
                      input logic [31:0] p0, input logic [31:0] p1, input logic st, input logic fl);
    @(negedge clk);
    fetch_valid = fv; fetch_instr0 = i0; fetch_instr1 = i1;
    fetch_pc0 = p0; fetch_pc1 = p1; issue_stall = st; flush = fl;
    #2;
  endtask

  task automatic idle(input logic st);
    step(2'b00, 32'd0, 32'd0, 32'd0, 32'd0, st, 1'b0);
  endtask

  task automatic test_reset;
    #3;
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
    checks++; if (fetch_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", fetch_ready); end
    checks++; if ({issue0_valid, issue1_valid} !== 2'b00) begin errors++; $display("FAIL reset_valid: got %b expected 00", {issue0_valid, issue1_valid}); end
    @(negedge clk); reset = 1'b1;
  endtask

  task automatic test_pair;
    logic [31:0] a, b;
    a = rtype(1, 2, 3, 32'h20); b = itype(6'h0d, 5, 4, 1);
    step(2'b11, a, b, 32'h100, 32'h104, 1'b0, 1'b0);
    checks++; if (issue0_valid !== 1'b0) begin errors++; $display("FAIL pair_same_cycle: got %b expected 0", issue0_valid); end
    idle(1'b0);
    checks++; if (count !== 4'd2) begin errors++; $display("FAIL pair_count2: got %0d expected 2", count); end
    checks++; if ({issue0_valid, issue1_valid} !== 2'b11) begin errors++; $display("FAIL pair_valid: got %b expected 11", {issue0_valid, issue1_valid}); end
    checks++; if (issue0_instr !== a || issue1_instr !== b) begin errors++; $display("FAIL pair_instr: got %h %h expected %h %h", issue0_instr, issue1_instr, a, b); end
    checks++; if (issue1_pc !== 32'h104) begin errors++; $display("FAIL pair_pc1: got %h expected 104", issue1_pc); end
    idle(1'b0);
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL pair_count0: got %0d expected 0", count); end
  endtask

  task automatic test_raw;
    logic [31:0] a, b;
    a = rtype(1, 2, 3, 32'h20); b = rtype(3, 4, 6, 32'h22);
    step(2'b11, a, b, 32'h110, 32'h114, 1'b0, 1'b0);
    idle(1'b0);
    checks++; if ({issue0_valid, issue1_valid} !== 2'b10) begin errors++; $display("FAIL raw_split: got %b expected 10", {issue0_valid, issue1_valid}); end
    idle(1'b0);
    checks++; if (issue0_valid !== 1'b1 || issue0_instr !== b) begin errors++; $display("FAIL raw_second: got %b %h expected 1 %h", issue0_valid, issue0_instr, b); end
    checks++; if (count !== 4'd1) begin errors++; $display("FAIL raw_count: got %0d expected 1", count); end
    idle(1'b0);
  endtask

  task automatic test_load_use;
    logic [31:0] a, b;
    a = itype(6'h23, 9, 8, 0); b = rtype(8, 1, 10, 32'h20);
    step(2'b11, a, b, 32'h120, 32'h124, 1'b0, 1'b0);
    idle(1'b0);
    checks++; if ({issue0_valid, issue1_valid} !== 2'b10 || issue0_instr !== a) begin errors++; $display("FAIL lu_load: got %b %h expected 10 %h", {issue0_valid, issue1_valid}, issue0_instr, a); end
    idle(1'b0);
    checks++; if (issue0_valid !== 1'b0) begin errors++; $display("FAIL lu_bubble: got %b expected 0", issue0_valid); end
    idle(1'b0);
    checks++; if (issue0_valid !== 1'b1 || issue0_instr !== b) begin errors++; $display("FAIL lu_use: got %b %h expected 1 %h", issue0_valid, issue0_instr, b); end
    idle(1'b0);
  endtask

  task automatic test_mem_branch;
    logic [31:0] a [3];
    logic [31:0] b [3];
    a[0] = itype(6'h23, 2, 1, 0);  b[0] = itype(6'h2b, 4, 3, 4);
    a[1] = itype(6'h04, 1, 2, 8);  b[1] = itype(6'h08, 6, 5, 1);
    a[2] = rtype(1, 2, 3, 32'h20); b[2] = itype(6'h05, 4, 5, 8);
    for (int i = 0; i < 3; i++) begin
      step(2'b11, a[i], b[i], 32'h130 + 32'(8*i), 32'h134 + 32'(8*i), 1'b0, 1'b0);
      idle(1'b0);
      checks++; if ({issue0_valid, issue1_valid} !== 2'b10) begin errors++; $display("FAIL membr_alone%0d: got %b expected 10", i, {issue0_valid, issue1_valid}); end
      idle(1'b0);
      checks++; if (issue0_valid !== 1'b1 || issue0_instr !== b[i]) begin errors++; $display("FAIL membr_next%0d: got %b %h expected 1 %h", i, issue0_valid, issue0_instr, b[i]); end
      idle(1'b0);
    end
  endtask

  task automatic test_full_wrap;
    for (int i = 0; i < 4; i++) begin
      step(2'b11, rtype(1, 2, 10 + 2*i, 32'h20), rtype(1, 2, 11 + 2*i, 32'h20),
           32'h200 + 32'(8*i), 32'h204 + 32'(8*i), 1'b1, 1'b0);
      checks++; if (fetch_ready !== 1'b1) begin errors++; $display("FAIL wrap_ready_fill%0d: got %b expected 1", i, fetch_ready); end
    end
    step(2'b11, 32'hdead_beef, 32'hdead_beef, 32'h999, 32'h99c, 1'b1, 1'b0);
    checks++; if (count !== 4'd8 || fetch_ready !== 1'b0) begin errors++; $display("FAIL wrap_full: got count %0d ready %b expected 8 0", count, fetch_ready); end
    for (int k = 0; k < 4; k++) begin
      idle(1'b0);
      checks++; if (count !== 4'(8 - 2*k) || fetch_ready !== (k != 0)) begin errors++; $display("FAIL wrap_count%0d: got %0d ready %b expected %0d", k, count, fetch_ready, 8 - 2*k); end
      checks++; if ({issue0_valid, issue1_valid} !== 2'b11 || issue0_pc !== 32'h200 + 32'(8*k) || issue1_pc !== 32'h204 + 32'(8*k))
        begin errors++; $display("FAIL wrap_order%0d: got %b %h %h expected 11 %h", k, {issue0_valid, issue1_valid}, issue0_pc, issue1_pc, 32'h200 + 32'(8*k)); end
    end
    idle(1'b0);
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL wrap_drain: got %0d expected 0", count); end
  endtask

  task automatic test_flush;
    step(2'b11, rtype(1, 2, 3, 32'h20), rtype(1, 2, 4, 32'h20), 32'h300, 32'h304, 1'b1, 1'b0);
    step(2'b11, rtype(1, 2, 5, 32'h20), rtype(1, 2, 6, 32'h20), 32'h308, 32'h30c, 1'b1, 1'b0);
    step(2'b10, rtype(1, 2, 7, 32'h20), rtype(1, 2, 8, 32'h20), 32'h310, 32'h314, 1'b1, 1'b0);
    step(2'b01, rtype(1, 2, 7, 32'h20), 32'd0, 32'h310, 32'h0, 1'b1, 1'b0);
    checks++; if (count !== 4'd4) begin errors++; $display("FAIL flush_valid10_ignored: got %0d expected 4", count); end
    step(2'b11, rtype(1, 2, 9, 32'h20), rtype(1, 2, 9, 32'h20), 32'h318, 32'h31c, 1'b0, 1'b1);
    checks++; if (count !== 4'd5 || {issue0_valid, issue1_valid} !== 2'b00) begin errors++; $display("FAIL flush_cycle: got count %0d valid %b expected 5 00", count, {issue0_valid, issue1_valid}); end
    idle(1'b0);
    checks++; if (count !== 4'd0 || fetch_ready !== 1'b1 || issue0_valid !== 1'b0) begin errors++; $display("FAIL flush_after: got count %0d ready %b v0 %b expected 0 1 0", count, fetch_ready, issue0_valid); end
  endtask

  task automatic test_reset_mid;
    step(2'b11, rtype(1, 2, 3, 32'h20), rtype(1, 2, 4, 32'h20), 32'h400, 32'h404, 1'b1, 1'b0);
    step(2'b11, rtype(1, 2, 5, 32'h20), rtype(1, 2, 6, 32'h20), 32'h408, 32'h40c, 1'b1, 1'b0);
    checks++; if (count !== 4'd2) begin errors++; $display("FAIL rstmid_pre: got %0d expected 2", count); end
    #1 reset = 1'b0;
    #1;
    checks++; if (count !== 4'd0 || fetch_ready !== 1'b1 || issue0_valid !== 1'b0) begin errors++; $display("FAIL rstmid_async: got count %0d ready %b v0 %b expected 0 1 0", count, fetch_ready, issue0_valid); end
    idle(1'b0);
    reset = 1'b1;
    idle(1'b0);
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL rstmid_after: got %0d expected 0", count); end
  endtask

  // Reference model: decode to a read-set bitmask and flags; queue of {instr, pc}.
  function automatic void mdec(input logic [31:0] ins, output logic [31:0] rd_set, output int dst,
                               output bit mem, output bit ld, output bit br, output bit ill);
    int op, rs, rt, rd;
    op = int'(ins[31:26]); rs = int'(ins[25:21]); rt = int'(ins[20:16]); rd = int'(ins[15:11]);
    rd_set = 0; dst = 0; mem = 0; ld = 0; br = 0; ill = 0;
    if (op == 0) begin rd_set = (32'd1 << rs) | (32'd1 << rt); dst = rd; end
    else if (op == 35) begin rd_set = 32'd1 << rs; dst = rt; mem = 1; ld = 1; end
    else if (op == 43) begin rd_set = (32'd1 << rs) | (32'd1 << rt); mem = 1; end
    else if (op == 4 || op == 5) begin rd_set = (32'd1 << rs) | (32'd1 << rt); br = 1; end
    else if (op == 15) dst = rt;
    else if (op >= 8 && op <= 14) begin rd_set = 32'd1 << rs; dst = rt; end
    else ill = 1;
  endfunction

  function automatic logic [31:0] rand_instr();
    int rs, rt, rd;
    rs = $urandom_range(0, 7); rt = $urandom_range(0, 7); rd = $urandom_range(0, 7);
    case ($urandom_range(0, 7))
      0: return rtype(rs, rt, rd, 32'h20);
      1: return itype(6'h23, rs, rt, $urandom_range(0, 255));
      2: return itype(6'h2b, rs, rt, 4);
      3: return itype(6'h04, rs, rt, 8);
      4: return itype(6'h05, rs, rt, 8);
      5: return itype($urandom_range(8, 14), rs, rt, 3);
      6: return itype(6'h0f, 0, rt, 16'h1234);
      default: return itype(6'h02, rs, rt, 0);
    endcase
  endfunction

  task automatic test_random;
    logic [63:0] q[$];
    int ld_reg;
    logic [31:0] pcn, i0, i1, rs0, rs1;
    logic [1:0] fv;
    logic st, fl, e0, e1, er;
    int n, dst0, dst1, nl;
    bit m0, l0, b0, x0, m1, l1, b1, x1;
    ld_reg = 0; pcn = 32'h1000;
    for (int cyc = 0; cyc < 600; cyc++) begin
      fv = 2'($urandom_range(0, 3));
      st = ($urandom_range(0, 3) == 0);
      fl = ($urandom_range(0, 40) == 0);
      i0 = rand_instr(); i1 = rand_instr();
      step(fv, i0, i1, pcn, pcn + 4, st, fl);
      n = q.size();
      er = (DEPTH - n) >= 2;
      rs0 = 0; rs1 = 0; dst0 = 0; dst1 = 0;
      {m0, l0, b0, x0, m1, l1, b1, x1} = '0;
      if (n >= 1) mdec(q[0][63:32], rs0, dst0, m0, l0, b0, x0);
      if (n >= 2) mdec(q[1][63:32], rs1, dst1, m1, l1, b1, x1);
      e0 = !fl && n >= 1 && !(ld_reg != 0 && rs0[ld_reg]);
      e1 = e0 && n >= 2 && !(dst0 != 0 && rs1[dst0]) && !(dst0 != 0 && dst1 == dst0)
           && !(m0 && m1) && !b0 && !b1 && !x0 && !x1 && !(ld_reg != 0 && rs1[ld_reg]);
      checks++; if (count !== 4'(n) || fetch_ready !== er) begin errors++; $display("FAIL rnd_count c%0d: got %0d ready %b expected %0d %b", cyc, count, fetch_ready, n, er); end
      checks++; if ({issue0_valid, issue1_valid} !== {e0, e1}) begin errors++; $display("FAIL rnd_valid c%0d: got %b expected %b", cyc, {issue0_valid, issue1_valid}, {e0, e1}); end
      if (e0) begin
        checks++; if ({issue0_instr, issue0_pc} !== q[0]) begin errors++; $display("FAIL rnd_slot0 c%0d: got %h %h expected %h", cyc, issue0_instr, issue0_pc, q[0]); end
      end
      if (e1) begin
        checks++; if ({issue1_instr, issue1_pc} !== q[1]) begin errors++; $display("FAIL rnd_slot1 c%0d: got %h %h expected %h", cyc, issue1_instr, issue1_pc, q[1]); end
      end
      if (fl) begin
        q.delete(); ld_reg = 0;
      end else begin
        nl = 0;
        if (!st) begin
          if (e0 && l0 && dst0 != 0) nl = dst0;
          else if (e1 && l1 && dst1 != 0) nl = dst1;
          if (e0) void'(q.pop_front());
          if (e1) void'(q.pop_front());
        end
        ld_reg = nl;
        if (er && fv[0]) begin
          q.push_back({i0, pcn});
          if (fv[1]) q.push_back({i1, pcn + 32'd4});
        end
      end
      pcn += 8;
    end
  endtask

  initial begin
    test_reset;
    test_pair;
    test_raw;
    test_load_use;
    test_mem_branch;
    test_full_wrap;
    test_flush;
    test_reset_mid;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
